// File: rtl/mem_access_unit.sv
// MEM stage of the pipeline: issues data-memory accesses, stalls the front end while
// an access is outstanding, resolves branches and registers results into MEM/WB.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  MEM_WB_ctl,
    input  logic [1:0]  MEM_M,
    input  logic        MEM_Branch,
    input  logic        MEM_Zero,
    input  logic [63:0] MEM_BranchTarget,
    input  logic [63:0] MEM_ALURes,
    input  logic [63:0] MEM_ReadData2,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic        stall,
    output logic        PCSrc,
    output logic [63:0] PC_BranchTarget,
    output logic [1:0]  WB_out,
    output logic [63:0] WB_ReadData,
    output logic [63:0] WB_ALURes,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] FC_NONE      = 2'b00;
    localparam logic [1:0] FC_MISALIGN  = 2'b01;
    localparam logic [1:0] FC_ILLEGAL   = 2'b10;
    localparam logic [1:0] FC_TIMEOUT   = 2'b11;

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic [7:0] count;

    logic       access;
    logic       illegal;
    logic       misaligned;
    logic       legal;
    logic       ack_valid;
    logic       timeout;
    logic       read_acked;
    logic [1:0] fault_nxt;

    // Decode of the memory-control pair; 2'b11 is not an access at all.
    assign access     = MEM_M[1] ^ MEM_M[0];
    assign illegal    = (MEM_M == 2'b11);
    assign misaligned = access && (MEM_ALURes[2:0] != 3'b000);
    assign legal      = access && !misaligned;

    assign dmem_req   = legal;
    assign dmem_we    = MEM_M[0];
    assign dmem_addr  = MEM_ALURes;
    assign dmem_wdata = MEM_ReadData2;

    // A stray ack with no request in flight must not move the FSM or load data.
    assign ack_valid  = dmem_req && dmem_ack;
    assign timeout    = (state == S_BUSY) && (count == TO_LAST) && !dmem_ack;
    assign read_acked = ack_valid && MEM_M[1];

    assign stall           = legal && !dmem_ack && !timeout;
    assign PCSrc           = MEM_Branch && MEM_Zero && !stall;
    assign PC_BranchTarget = MEM_BranchTarget;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (dmem_req && !dmem_ack) state_nxt = S_BUSY;
            S_BUSY:  if (ack_valid || timeout)  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Illegal outranks misaligned outranks timeout.
    always_comb begin
        fault_nxt = FC_NONE;
        if (illegal)         fault_nxt = FC_ILLEGAL;
        else if (misaligned) fault_nxt = FC_MISALIGN;
        else if (timeout)    fault_nxt = FC_TIMEOUT;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            count <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE || state_nxt == S_IDLE)
                count <= 8'd0;
            else if (!ack_valid)
                count <= count + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WB_out      <= 2'b00;
            WB_ReadData <= 64'd0;
            WB_ALURes   <= 64'd0;
            fault       <= 1'b0;
            fault_code  <= FC_NONE;
        end else begin
            fault      <= (fault_nxt != FC_NONE);
            fault_code <= fault_nxt;
            if (stall) begin
                WB_out <= 2'b00;
            end else begin
                // A faulting instruction still advances, but as a bubble.
                WB_out    <= (fault_nxt != FC_NONE) ? 2'b00 : MEM_WB_ctl;
                WB_ALURes <= MEM_ALURes;
                if (read_acked)
                    WB_ReadData <= dmem_rdata;
            end
        end
    end

endmodule
